// File: rtl/prog_loader.sv
// Streams a length-prefixed program of 16-bit words into instruction memory while holding the CPU.
// Optional trailing XOR checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned MAX_WORDS = 512
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHK, DONE, ERR
  } state_t;

  state_t      state_q, state_d, state_end;
  logic [7:0]  len_lo_q;
  logic [7:0]  data_lo_q;
  logic [15:0] count_q;
  logic [15:0] count_full;
  logic        accept;
  logic        last_word;
  logic        restart;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  assign accept     = rx_valid && rx_ready;
  assign count_full = {rx_data, len_lo_q};
  assign last_word  = (words_loaded + 16'd1) == count_q;
  assign restart    = start && (state_q == IDLE || state_q == DONE || state_q == ERR);

  always_comb begin
    state_d   = state_q;
    rx_ready  = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    state_end = CHK;
`else
    state_end = DONE;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) state_d = LEN_LO;
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        if (accept) state_d = LEN_HI;
      end
      LEN_HI: begin
        rx_ready = 1'b1;
        if (accept) begin
          if ({16'h0000, count_full} > MAX_WORDS) state_d = ERR;
          else if (count_full == 16'h0000)       state_d = state_end;
          else                                   state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        rx_ready = 1'b1;
        if (accept) state_d = DATA_HI;
      end
      DATA_HI: begin
        rx_ready = 1'b1;
        if (accept) state_d = last_word ? state_end : DATA_LO;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: begin
        rx_ready = 1'b1;
        if (accept) state_d = (rx_data == csum_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done     = (state_q == DONE);
    error    = (state_q == ERR);
    cpu_hold = (state_q != DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= '0;
      words_loaded <= '0;
      len_lo_q     <= '0;
      data_lo_q    <= '0;
      count_q      <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q <= state_d;
      imem_we <= 1'b0;
      if (restart) begin
        words_loaded <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_q       <= '0;
`endif
      end
      if (accept) begin
        case (state_q)
          LEN_LO:  len_lo_q  <= rx_data;
          LEN_HI:  count_q   <= count_full;
          DATA_LO: data_lo_q <= rx_data;
          DATA_HI: begin
            // Address uses the pre-increment count; both update on the same edge.
            imem_we      <= 1'b1;
            imem_wdata   <= {rx_data, data_lo_q};
            imem_addr    <= BASE_ADDR + words_loaded;
            words_loaded <= words_loaded + 16'd1;
          end
          default: ;
        endcase
`ifdef PROG_LOADER_CHECKSUM_EN
        if (state_q != CHK) csum_q <= csum_q ^ rx_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued by the stimulus and checked by a monitor.
module tb_prog_loader;
  localparam logic [15:0] BASE = 16'h0000;
  localparam int unsigned MAXW = 512;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready, imem_we, cpu_hold, done, error;
  logic [15:0] imem_addr, imem_wdata, words_loaded;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] cnt;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] words_q[$];
  int          tests = 0;
  int          fails = 0;

  prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge CLK);
      if (imem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {imem_addr, imem_wdata}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {16'h0, imem_addr}, {16'h0, e.addr});
          check("wr_data", {16'h0, imem_wdata}, {16'h0, e.data});
          check("wr_count", {16'h0, words_loaded}, {16'h0, e.cnt});
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic send(input logic [7:0] b, input int gmin, input int gmax);
    int gap, tries;
    gap = $urandom_range(gmax, gmin);
    repeat (gap) begin
      @(negedge CLK);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
    @(negedge CLK);
    rx_valid = 1'b1;
    rx_data  = b;
    #1;
    tries = 0;
    while (rx_ready !== 1'b1 && tries < 50) begin
      @(negedge CLK);
      #1;
      tries++;
    end
    if (rx_ready !== 1'b1) check("rx_ready_timeout", {31'h0, rx_ready}, 32'h1);
    @(posedge CLK);
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    rx_valid = 1'b0;
    start    = 1'b1;
    @(negedge CLK);
    start    = 1'b0;
  endtask

  task automatic fill_random(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back(16'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, {31'h0, rx_ready}, 32'h0);
    check({tag, "_imem_we"}, {31'h0, imem_we}, 32'h0);
    check({tag, "_imem_addr"}, {16'h0, imem_addr}, {16'h0, BASE});
    check({tag, "_imem_wdata"}, {16'h0, imem_wdata}, 32'h0);
    check({tag, "_cpu_hold"}, {31'h0, cpu_hold}, 32'h1);
    check({tag, "_done"}, {31'h0, done}, 32'h0);
    check({tag, "_error"}, {31'h0, error}, 32'h0);
    check({tag, "_words"}, {16'h0, words_loaded}, 32'h0);
  endtask

  // Runs one full load of words_q with count n; the expected outcome is derived from the stream rules.
  task automatic load(input string tag, input logic [15:0] n, input int gmin, input int gmax,
                      input bit bad_chk, input bit midstart);
    logic [7:0] x;
    bit exp_err;
    int waited;
    x = n[7:0] ^ n[15:8];
    exp_err = ({16'h0, n} > MAXW);
    pulse_start();
    check({tag, "_busy_hold"}, {31'h0, cpu_hold}, 32'h1);
    check({tag, "_busy_done"}, {30'h0, done, error}, 32'h0);
    send(n[7:0], gmin, gmax);
    send(n[15:8], gmin, gmax);
    if (!exp_err) begin
      for (int i = 0; i < int'(n); i++) begin
        exp_q.push_back('{addr: BASE + 16'(i), data: words_q[i], cnt: 16'(i + 1)});
        send(words_q[i][7:0], gmin, gmax);
        send(words_q[i][15:8], gmin, gmax);
        x = x ^ words_q[i][7:0] ^ words_q[i][15:8];
        if (midstart && i == 0) pulse_start();
      end
      if (CHK_EN) begin
        send(bad_chk ? (x ^ 8'h01) : x, gmin, gmax);
        exp_err = bad_chk;
      end
    end
    @(negedge CLK);
    rx_valid = 1'b0;
    waited = 0;
    while (!(done === 1'b1 || error === 1'b1) && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    #1;
    check({tag, "_done"}, {31'h0, done}, {31'h0, !exp_err});
    check({tag, "_error"}, {31'h0, error}, {31'h0, exp_err});
    check({tag, "_cpu_hold"}, {31'h0, cpu_hold}, {31'h0, exp_err});
    check({tag, "_words"}, {16'h0, words_loaded}, ({16'h0, n} > MAXW) ? 32'h0 : {16'h0, n});
    check({tag, "_rx_ready_end"}, {31'h0, rx_ready}, 32'h0);
    repeat (2) @(negedge CLK);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [15:0] wl;
    // Reset dominates simultaneous start and rx_valid.
    start = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h5A;
    repeat (3) @(negedge CLK);
    start = 1'b0;
    rx_valid = 1'b0;
    RST = 1'b0;
    #1;
    check_reset_outputs("reset");

    // Idle ignores incoming bytes.
    @(negedge CLK);
    rx_valid = 1'b1;
    repeat (3) @(negedge CLK);
    rx_valid = 1'b0;
    #1;
    check("idle_rx_ready", {31'h0, rx_ready}, 32'h0);
    check("idle_hold", {31'h0, cpu_hold}, 32'h1);

    words_q = '{16'h1234, 16'h5678};
    load("b2b", 16'd2, 0, 0, 1'b0, 1'b0);

    // Bytes in DONE have no effect.
    wl = words_loaded;
    @(negedge CLK);
    rx_valid = 1'b1;
    rx_data = 8'hC3;
    repeat (4) @(negedge CLK);
    rx_valid = 1'b0;
    #1;
    check("done_ignore_words", {16'h0, words_loaded}, {16'h0, wl});
    check("done_ignore_state", {31'h0, done}, 32'h1);

    words_q = '{16'h1234, 16'h5678};
    load("gap3", 16'd2, 3, 3, 1'b0, 1'b0);

    load("over_max", 16'd513, 0, 0, 1'b0, 1'b0);

    words_q.delete();
    load("zero", 16'd0, 0, 1, 1'b0, 1'b0);

    fill_random(3);
    load("midstart", 16'd3, 0, 2, 1'b0, 1'b1);

    // Reset part-way through the second word: one write survives, nothing after.
    pulse_start();
    send(8'h02, 0, 0);
    send(8'h00, 0, 0);
    exp_q.push_back('{addr: BASE, data: 16'h1234, cnt: 16'd1});
    send(8'h34, 0, 0);
    send(8'h12, 0, 0);
    send(8'h78, 0, 0);
    @(negedge CLK);
    rx_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge CLK);
    check("midreset_pending", exp_q.size(), 0);

    words_q = '{16'h55AA};
    load("chk_good", 16'd1, 0, 0, 1'b0, 1'b0);
    words_q = '{16'h55AA};
    load("chk_bad", 16'd1, 0, 0, 1'b1, 1'b0);

    fill_random(int'(MAXW));
    load("max_words", 16'(MAXW), 0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(6, 0);
      fill_random(n);
      load("random", 16'(n), 0, 3, bit'($urandom_range(1, 0)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0000: instruction-memory address of the first loaded word.
REQ-002 Parameter MAX_WORDS, default 512: largest accepted word count.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin a load.
REQ-006 rx_valid  input  1  byte present on rx_data.
REQ-007 rx_data  input  8  incoming stream byte.
REQ-008 rx_ready  output  1  loader accepts a byte this cycle.
REQ-009 imem_we  output  1  instruction-memory write strobe.
REQ-010 imem_addr  output  16  instruction-memory write address.
REQ-011 imem_wdata  output  16  instruction word to write.
REQ-012 cpu_hold  output  1  keeps the pipeline stalled, with PC held, while high.
REQ-013 done  output  1  load completed successfully.
REQ-014 error  output  1  load aborted.
REQ-015 words_loaded  output  16  count of words written in the current or last load.

Function
REQ-016 A byte SHALL be accepted only in a cycle where rx_valid and rx_ready are both high.
REQ-017 The stream format SHALL be: count low byte, count high byte, then count words, each sent low byte first.
REQ-018 The states SHALL be IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHK, DONE and ERR.
REQ-019 rx_ready SHALL be high exactly in LEN_LO, LEN_HI, DATA_LO, DATA_HI and CHK.
REQ-020 start SHALL move IDLE, DONE or ERR to LEN_LO.
- The same transition SHALL clear done, error and words_loaded.
- The same transition SHALL set cpu_hold.
- start in any other state SHALL be ignored.
REQ-021 An accepted byte in LEN_LO SHALL store the count low byte and move to LEN_HI.
REQ-022 An accepted byte in LEN_HI SHALL complete the 16-bit count N, then:
- N > MAX_WORDS: go to ERR.
- N = 0: go to CHK if CHECKSUM_EN is defined, otherwise to DONE.
- otherwise: go to DATA_LO.
REQ-023 An accepted byte in DATA_LO SHALL be latched as the word low byte, then go to DATA_HI.
REQ-024 On an accepted byte in DATA_HI, the next cycle SHALL have:
- imem_we high for exactly one cycle;
- imem_wdata = {byte, latched low byte};
- imem_addr = BASE_ADDR + words_loaded, computed modulo 2^16.
REQ-025 words_loaded SHALL increment in the same cycle as the imem_we pulse.
REQ-026 After the DATA_HI byte of word N the FSM SHALL go to CHK (CHECKSUM_EN) or DONE; otherwise it SHALL return to DATA_LO.
REQ-027 Back-to-back bytes (rx_valid high every cycle) SHALL be accepted with no bubble; a write and the acceptance of the next byte may coincide.
REQ-028 imem_we SHALL never be asserted outside the cycle following a DATA_HI accept.
REQ-029 DONE SHALL drive done=1 and cpu_hold=0, and SHALL hold until start or RST.
REQ-030 ERR SHALL drive error=1 and cpu_hold=1; only start or RST SHALL leave ERR.
REQ-031 In IDLE, cpu_hold SHALL remain at its reset value of 1.
REQ-032 rx_valid in IDLE, DONE or ERR SHALL have no effect.

Reset
REQ-033 RST high at a clock edge SHALL force IDLE.
- Outputs: rx_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0.
REQ-034 RST SHALL take priority over start and rx_valid.
REQ-035 RST mid-load SHALL abandon the load with no further imem_we; words already written SHALL NOT be rolled back.

Configuration
REQ-036 Macro PROG_LOADER_CHECKSUM_EN.
- Defined: CHK accepts one byte; it SHALL equal the XOR of all count and data bytes.
- Match: go to DONE. Mismatch: go to ERR.
- Undefined: CHK SHALL be unreachable, and the XOR accumulator SHALL NOT be built.

Verification
REQ-037 RST, start, bytes 02 00 34 12 78 56 with no gaps.
- imem_we pulses at 0x0000 with wdata 0x1234, then at 0x0001 with 0x5678.
- Result: words_loaded=2, done=1, cpu_hold=0.
REQ-038 Same stream with a 3-cycle rx_valid gap between each byte -> identical writes and end state.
REQ-039 Count bytes 01 02 (N=513 > 512) -> ERR, error=1, cpu_hold=1, no imem_we.
REQ-040 RST after 3 data bytes of a 2-word load -> exactly one write occurred, then IDLE with all outputs at reset values.
REQ-041 With CHECKSUM_EN, stream 01 00 AA 55 FE (XOR=FE) -> done=1; a final byte of FF instead -> error=1.
REQ-042 start pulsed during DATA_LO -> ignored; the load completes normally.
